// File: rtl/mau_pkg.sv
// ---------------------------------------------------------------------------
// mau_pkg
// Shared widths and state encoding for the memory address unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mau_pkg;
  localparam int MAU_AW = 16;
  localparam int MAU_SW = 4;
  localparam int MAU_LW = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mau_state_t;
endpackage

`default_nettype wire

// File: rtl/mau_if.sv
// ---------------------------------------------------------------------------
// mau_if
// Control/bus signal bundle between the control unit and the address unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mau_if #(
  parameter int AW = mau_pkg::MAU_AW,
  parameter int SW = mau_pkg::MAU_SW,
  parameter int LW = mau_pkg::MAU_LW
);
  logic [AW-1:0] MAU_in;
  logic          MAU_wr_en;
  logic [AW-1:0] MAU_limit;
  logic [SW-1:0] MAU_stride;
  logic          MAU_inc_en;
  logic          MAU_burst_start;
  logic [LW-1:0] MAU_burst_len;
  logic          MAU_ready;
  logic [AW-1:0] MAU_out;
  logic          MAU_valid;
  logic          MAU_busy;
  logic          MAU_done;

  modport master (
    output MAU_in, MAU_wr_en, MAU_limit, MAU_stride, MAU_inc_en,
           MAU_burst_start, MAU_burst_len, MAU_ready,
    input  MAU_out, MAU_valid, MAU_busy, MAU_done
  );

  modport slave (
    input  MAU_in, MAU_wr_en, MAU_limit, MAU_stride, MAU_inc_en,
           MAU_burst_start, MAU_burst_len, MAU_ready,
    output MAU_out, MAU_valid, MAU_busy, MAU_done
  );
endinterface

`default_nettype wire

// File: rtl/mau_next_addr.sv
// ---------------------------------------------------------------------------
// mau_next_addr
// Combinational next-address: addr + stride, optionally wrapped to base.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mau_next_addr #(
  parameter int AW      = mau_pkg::MAU_AW,
  parameter int SW      = mau_pkg::MAU_SW,
  parameter bit WRAP_EN = 1'b1
) (
  input  wire logic [AW-1:0] addr,
  input  wire logic [SW-1:0] stride,
  input  wire logic [AW-1:0] base,
  input  wire logic [AW-1:0] limit,
  output logic      [AW-1:0] next
);
  logic [AW:0] w_sum;
  logic        w_over;

  // Sum is one bit wider so a carry out of the top counts as exceeding limit.
  assign w_sum  = {1'b0, addr} + (AW+1)'(stride);
  assign w_over = w_sum > {1'b0, limit};
  assign next   = (WRAP_EN && w_over) ? base : w_sum[AW-1:0];
endmodule

`default_nettype wire

// File: rtl/memory_address_unit.sv
// ---------------------------------------------------------------------------
// memory_address_unit
// Address register with load, strided step, window wrap and burst sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_address_unit
  import mau_pkg::*;
#(
  parameter int AW      = MAU_AW,
  parameter int SW      = MAU_SW,
  parameter int LW      = MAU_LW,
  parameter bit WRAP_EN = 1'b1
) (
  input wire logic MAU_clk,
  input wire logic MAU_rst,
  mau_if.slave     bus
);
  mau_state_t    r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_count;
  logic          r_valid;
  logic          r_done;
  logic [AW-1:0] w_next;

  mau_next_addr #(
    .AW      (AW),
    .SW      (SW),
    .WRAP_EN (WRAP_EN)
  ) u_next_addr (
    .addr   (r_addr),
    .stride (bus.MAU_stride),
    .base   (r_base),
    .limit  (bus.MAU_limit),
    .next   (w_next)
  );

  always_ff @(posedge MAU_clk) begin
    if (MAU_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_base  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.MAU_wr_en) begin
            r_addr <= bus.MAU_in;
            r_base <= bus.MAU_in;
          end else if (bus.MAU_burst_start) begin
            if (bus.MAU_burst_len != '0) begin
              r_count <= bus.MAU_burst_len;
              r_state <= BURST;
              r_valid <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end else if (bus.MAU_inc_en) begin
            r_addr <= w_next;
          end
        end
        BURST: begin
          // A load aborts the burst silently: no done pulse.
          if (bus.MAU_wr_en) begin
            r_addr  <= bus.MAU_in;
            r_base  <= bus.MAU_in;
            r_count <= '0;
            r_state <= IDLE;
            r_valid <= 1'b0;
          end else if (r_valid && bus.MAU_ready) begin
            r_addr  <= w_next;
            r_count <= r_count - LW'(1);
            if (r_count == LW'(1)) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MAU_out   = r_addr;
  assign bus.MAU_valid = r_valid;
  assign bus.MAU_busy  = (r_state == BURST);
  assign bus.MAU_done  = r_done;
endmodule

`default_nettype wire

// File: doc/memory_address_unit.md
Name: memory_address_unit

Overview:
Parametrised successor to the 16-bit memory address register. It holds the current memory address and supports direct load and single-step increment by a programmable stride. It wraps inside a [base, limit] window and runs an autonomous burst sequencer that presents N consecutive addresses under a valid/ready handshake. It sits between the control unit / instruction decoder and the memory address bus.

Parameters:
- AW, 16, address width in bits.
- SW, 4, stride width in bits; stride is zero-extended to AW.
- LW, 8, burst-length width in bits.
- WRAP_EN, 1, 1 = wrap to base when the next address exceeds limit; 0 = plain modulo-2^AW wrap.

Ports:
- MAU_clk  in  1  clock; all state updates on the rising edge.
- MAU_rst  in  1  synchronous, active-high reset.
- MAU_in  in  AW  address to load; also latched as window base.
- MAU_wr_en  in  1  load MAU_in into the address and base registers.
- MAU_limit  in  AW  upper bound of the wrap window, sampled every cycle.
- MAU_stride  in  SW  increment amount, sampled every cycle.
- MAU_inc_en  in  1  single step: address <= next address (IDLE only).
- MAU_burst_start  in  1  start a burst (IDLE only).
- MAU_burst_len  in  LW  beats in the burst, sampled on start.
- MAU_ready  in  1  consumer accepts the current burst address.
- MAU_out  out  AW  current address, combinational copy of the address register.
- MAU_valid  out  1  burst address on MAU_out is valid.
- MAU_busy  out  1  FSM is in BURST.
- MAU_done  out  1  one-cycle pulse when a burst ends.

Behaviour:
- Reset (synchronous, active-high): address = 0, base = 0, beat counter = 0, state = IDLE, MAU_valid = 0, MAU_busy = 0, MAU_done = 0. Reset overrides every other input.
- Load stores MAU_in unmodified. There is no implicit +1. The new value appears on MAU_out the cycle after the wr_en edge.
- Next-address rule:
  - sum = {1'b0, addr} + zero-extended stride, computed in AW+1 bits.
  - WRAP_EN = 1 and sum > {1'b0, MAU_limit}: next = base.
  - Otherwise: next = sum[AW-1:0].
  - A stride of 0 leaves the address unchanged.
- Priority, highest first: rst > wr_en > burst_start > inc_en.
- States: IDLE, BURST.
- IDLE:
  - wr_en loads the address and base.
  - burst_start with len > 0: count = len, go to BURST.
  - burst_start with len = 0: stay in IDLE, MAU_done = 1 for one cycle, address unchanged.
  - Otherwise inc_en applies a single step.
- BURST:
  - MAU_valid = 1 and MAU_busy = 1.
  - The first beat presents the address held at start, with no pre-increment.
  - Beat accepted when valid && ready: address <= next, count <= count - 1.
  - When the final beat is accepted (count == 1): go to IDLE, MAU_done = 1 on the following cycle, valid = 0.
  - After a completed burst the address points one stride past the last beat.
  - ready = 0 holds the address and count stable; valid stays high (no retraction).
  - inc_en and burst_start are ignored.
  - wr_en aborts the burst: load MAU_in, go to IDLE, valid = 0, no done pulse.
- Timing: MAU_done and MAU_valid are registered. MAU_out is combinational from the register, so there is no extra delay.
- Reset mid-burst returns everything to reset values; no done pulse.
- Maximum burst length is 2^LW - 1 beats.

Decomposition:
- Shared package (mau_pkg): state encoding constants (IDLE = 1'b0, BURST = 1'b1) and default widths AW/SW/LW.
- Sub-module mau_next_addr: purely combinational; inputs addr, stride, base, limit; parameter WRAP_EN; output next. It is shared by the single-step and burst paths.
- Top level holds the registers and the FSM.

Test Plan:
1. Reset, then wr_en with MAU_in = 0x1000, next cycle -> MAU_out = 0x1000; busy = valid = done = 0.
2. Load 0x0010, stride = 4, limit = 0xFFFF, pulse inc_en 3 times -> MAU_out = 0x0014, 0x0018, 0x001C.
3. WRAP_EN = 1: load base 0x0100, limit = 0x0108, stride = 4, inc ×3 -> 0x0104, 0x0108, 0x0100 (wrap). WRAP_EN = 0 at 0xFFFE with stride 4 -> 0x0002.
4. Load 0x0200, stride = 2, start burst len = 4 with ready = 1 -> valid for 4 cycles with MAU_out = 0x0200, 0x0202, 0x0204, 0x0206; done pulse; final MAU_out = 0x0208, busy = 0.
5. Burst len = 3 with ready toggled 1,0,0,1,1 -> address holds during ready = 0; exactly 3 beats accepted; done after the third; inc_en pulsed mid-burst has no effect.
6. wr_en = 0x0500 during beat 2 of a len = 5 burst -> IDLE next cycle, MAU_out = 0x0500, no done. burst_start with len = 0 -> single done pulse, address unchanged. MAU_rst mid-burst -> all outputs 0.
